isa_bus_ctl: RTL and testbench

ISA_BUS_CTL -- requirements
Module: isa_bus_ctl

---
 rtl/isa_bus_ctl.sv | 208 ++++++++++++++++++++
 tb/tb_isa_bus_ctl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_bus_ctl.sv
// ISA bus target controller: strobe sync, window decode,
// memory handshake with wait states and timeout, I/O access.
module isa_bus_ctl #(
  parameter logic [15:0] IO_BASE     = 16'h03B0,
  parameter int          IO_AW       = 4,
  parameter logic [19:0] MEM_BASE    = 20'hB0000,
  parameter int          MEM_AW      = 15,
  parameter int          SYNC_STAGES = 2,
  parameter int          WAIT_EN     = 1,
  parameter logic [7:0]  TIMEOUT     = 8'd64
) (
  input  logic              clk,
  input  logic              busreset,
  input  logic [19:0]       bus_a,
  input  logic              bus_ior_l,
  input  logic              bus_iow_l,
  input  logic              bus_memr_l,
  input  logic              bus_memw_l,
  input  logic              bus_aen,
  input  logic [7:0]        bus_din,
  output logic [7:0]        bus_out,
  output logic              bus_dir,
  output logic              bus_rdy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              io_wr,
  output logic [IO_AW-1:0]  io_addr,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    MREQ,
    HOLD
  } state_t;

  localparam int IOR  = 0;
  localparam int IOW  = 1;
  localparam int MEMR = 2;
  localparam int MEMW = 3;

  state_t              state_q;
  logic [3:0]          strb_raw;
  logic [3:0]          sync_q [SYNC_STAGES];
  logic [3:0]          prev_q;
  logic [SYNC_STAGES:0] vld_q;
  logic [3:0]          strb_s;
  logic [3:0]          fall_d;
  logic [3:0]          acc_d;
  logic                io_hit;
  logic                mem_hit;
  logic                rd_done;

  logic [7:0]          bus_out_q;
  logic                bus_dir_q;
  logic                bus_rdy_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                io_wr_q;
  logic [IO_AW-1:0]    io_addr_q;
  logic [7:0]          io_wdata_q;
  logic                timeout_err_q;
  logic [7:0]          cnt_q;
  logic [3:0]          rd_sel_q;

  assign strb_raw = {bus_memw_l, bus_memr_l,
                     bus_iow_l, bus_ior_l};

  // Strobe synchronisers; vld_q marks when prev_q holds a
  // real post-reset sample so a held-low strobe is not an edge.
  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'hF;
      end
      prev_q <= 4'hF;
      vld_q  <= '0;
    end else begin
      sync_q[0] <= strb_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign strb_s = sync_q[SYNC_STAGES-1];
  assign fall_d = {4{vld_q[SYNC_STAGES]}}
                & prev_q & ~strb_s;

  assign io_hit  = ~bus_aen
                 & (bus_a[15:IO_AW]
                    == IO_BASE[15:IO_AW]);
  assign mem_hit = ~bus_aen
                 & (bus_a[19:MEM_AW]
                    == MEM_BASE[19:MEM_AW]);

  assign acc_d = fall_d
               & {mem_hit, mem_hit, io_hit, io_hit};

  // Read strobe being tracked for bus_dir has gone high again.
  assign rd_done = bus_dir_q & |(rd_sel_q & strb_s);

  // Cycle FSM with registered bus and back-end outputs.
  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      state_q       <= IDLE;
      bus_out_q     <= 8'h00;
      bus_dir_q     <= 1'b0;
      bus_rdy_q     <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 8'h00;
      io_wr_q       <= 1'b0;
      io_addr_q     <= '0;
      io_wdata_q    <= 8'h00;
      timeout_err_q <= 1'b0;
      cnt_q         <= 8'h00;
      rd_sel_q      <= 4'h0;
    end else begin
      io_wr_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      if (rd_done) begin
        bus_dir_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (acc_d[MEMW] | acc_d[MEMR]) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= acc_d[MEMW];
            mem_addr_q  <= bus_a[MEM_AW-1:0];
            mem_wdata_q <= bus_din;
            bus_rdy_q   <= (WAIT_EN == 0);
            cnt_q       <= 8'h00;
            state_q     <= MREQ;
            if (!acc_d[MEMW]) begin
              bus_dir_q <= 1'b1;
              rd_sel_q  <= 4'b0100;
            end
          end else if (acc_d[IOW]) begin
            io_wr_q    <= 1'b1;
            io_addr_q  <= bus_a[IO_AW-1:0];
            io_wdata_q <= bus_din;
            state_q    <= HOLD;
          end else if (acc_d[IOR]) begin
            io_addr_q <= bus_a[IO_AW-1:0];
            bus_out_q <= io_rdata;
            bus_dir_q <= 1'b1;
            rd_sel_q  <= 4'b0001;
            state_q   <= HOLD;
          end
        end
        MREQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            bus_rdy_q <= 1'b1;
            if (!mem_we_q) begin
              bus_out_q <= mem_rdata;
            end
            state_q <= HOLD;
          end else if (cnt_q == TIMEOUT - 8'd1) begin
            mem_req_q     <= 1'b0;
            bus_rdy_q     <= 1'b1;
            timeout_err_q <= 1'b1;
            if (!mem_we_q) begin
              bus_out_q <= 8'hFF;
            end
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (&strb_s) begin
            bus_dir_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_out     = bus_out_q;
  assign bus_dir     = bus_dir_q;
  assign bus_rdy     = bus_rdy_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign io_wr       = io_wr_q;
  assign io_addr     = io_addr_q;
  assign io_wdata    = io_wdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_isa_bus_ctl.sv
// Directed bench for isa_bus_ctl: I/O and memory cycles,
// window misses, timeout, priority and reset behaviour.
module tb_isa_bus_ctl;

  logic        clk = 1'b0;
  logic        busreset;
  logic [19:0] bus_a;
  logic        bus_ior_l, bus_iow_l;
  logic        bus_memr_l, bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_din;
  logic [7:0]  bus_out;
  logic        bus_dir, bus_rdy;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        io_wr;
  logic [3:0]  io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  int n_iowr;
  logic seen_req, seen_dir;
  logic [3:0] cap_addr;
  logic [7:0] cap_wdata;
  int n;

  always #5 clk = ~clk;

  isa_bus_ctl dut (
    .clk        (clk),
    .busreset   (busreset),
    .bus_a      (bus_a),
    .bus_ior_l  (bus_ior_l),
    .bus_iow_l  (bus_iow_l),
    .bus_memr_l (bus_memr_l),
    .bus_memw_l (bus_memw_l),
    .bus_aen    (bus_aen),
    .bus_din    (bus_din),
    .bus_out    (bus_out),
    .bus_dir    (bus_dir),
    .bus_rdy    (bus_rdy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .io_wr      (io_wr),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_iowr    = 0;
    seen_req  = 1'b0;
    seen_dir  = 1'b0;
    cap_addr  = 4'h0;
    cap_wdata = 8'h00;
  endtask

  task automatic mon(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1);
      if (io_wr) begin
        n_iowr++;
        cap_addr  = io_addr;
        cap_wdata = io_wdata;
      end
      if (mem_req) seen_req = 1'b1;
      if (bus_dir) seen_dir = 1'b1;
    end
  endtask

  task automatic wait_req();
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!mem_req && n < 10);
  endtask

  initial begin
    busreset   = 1'b1;
    bus_a      = 20'h0;
    bus_ior_l  = 1'b1;
    bus_iow_l  = 1'b1;
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    bus_aen    = 1'b0;
    bus_din    = 8'h00;
    mem_ack    = 1'b0;
    mem_rdata  = 8'h00;
    io_rdata   = 8'h00;
    clr();
    cyc(3);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_bus_rdy", bus_rdy, 1);
    chk("rst_bus_dir", bus_dir, 0);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_io_wr", io_wr, 0);
    chk("rst_timeout", timeout_err, 0);
    busreset = 1'b0;
    cyc(5);

    // I/O write 0x3B5 <- 0x0E
    bus_a   = 20'h003B5;
    bus_din = 8'h0E;
    clr();
    bus_iow_l = 1'b0;
    mon(5);
    bus_din = 8'h55;
    mon(3);
    chk("iow_pulses", n_iowr, 1);
    chk("iow_addr", cap_addr, 4'h5);
    chk("iow_data", cap_wdata, 8'h0E);
    chk("iow_data_held", io_wdata, 8'h0E);
    chk("iow_dir", seen_dir, 0);
    bus_iow_l = 1'b1;
    cyc(5);

    // memory read 0xB0123, ack after 5 cycles
    bus_a = 20'hB0123;
    bus_memr_l = 1'b0;
    wait_req();
    chk("memr_lat", n, 3);
    chk("memr_addr", mem_addr, 15'h0123);
    chk("memr_we", mem_we, 0);
    chk("memr_rdy_wait", bus_rdy, 0);
    chk("memr_dir", bus_dir, 1);
    bus_a = 20'h00000;
    cyc(4);
    chk("memr_req_hold", mem_req, 1);
    chk("memr_rdy_hold", bus_rdy, 0);
    chk("memr_addr_latched", mem_addr, 15'h0123);
    mem_rdata = 8'h41;
    mem_ack   = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    chk("memr_data", bus_out, 8'h41);
    chk("memr_rdy_done", bus_rdy, 1);
    chk("memr_req_drop", mem_req, 0);
    chk("memr_dir_held", bus_dir, 1);
    bus_memr_l = 1'b1;
    cyc(4);
    chk("memr_dir_rel", bus_dir, 0);
    mem_rdata = 8'h99;
    mem_ack   = 1'b1;
    clr();
    mon(4);
    mem_ack = 1'b0;
    chk("stray_ack_req", seen_req, 0);
    chk("stray_ack_out", bus_out, 8'h41);

    // window misses and DMA cycles
    bus_a   = 20'hB8000;
    bus_din = 8'h12;
    clr();
    bus_memw_l = 1'b0;
    mon(8);
    bus_memw_l = 1'b1;
    mon(4);
    bus_a    = 20'h003B5;
    bus_aen  = 1'b1;
    io_rdata = 8'h77;
    bus_ior_l = 1'b0;
    mon(8);
    bus_ior_l = 1'b1;
    bus_aen   = 1'b0;
    mon(4);
    bus_a = 20'h003C5;
    bus_iow_l = 1'b0;
    mon(8);
    bus_iow_l = 1'b1;
    mon(4);
    chk("miss_req", seen_req, 0);
    chk("miss_iowr", n_iowr, 0);
    chk("miss_dir", seen_dir, 0);
    chk("miss_out", bus_out, 8'h41);

    // I/O read, upper address bits ignored
    bus_a    = 20'hA03B5;
    io_rdata = 8'h5A;
    bus_ior_l = 1'b0;
    cyc(4);
    chk("ior_data", bus_out, 8'h5A);
    chk("ior_dir", bus_dir, 1);
    chk("ior_rdy", bus_rdy, 1);
    bus_ior_l = 1'b1;
    cyc(4);
    chk("ior_dir_rel", bus_dir, 0);

    // memory read timeout
    bus_a = 20'hB0000;
    bus_memr_l = 1'b0;
    wait_req();
    chk("to_req", mem_req, 1);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!timeout_err && n < 100);
    chk("to_lat", n, 64);
    chk("to_out", bus_out, 8'hFF);
    chk("to_rdy", bus_rdy, 1);
    chk("to_req_drop", mem_req, 0);
    cyc(1);
    chk("to_pulse", timeout_err, 0);
    bus_memr_l = 1'b1;
    cyc(4);

    // memw and iow together; later iow edge in MREQ
    bus_a   = 20'hB03B5;
    bus_din = 8'hC3;
    clr();
    bus_memw_l = 1'b0;
    bus_iow_l  = 1'b0;
    mon(4);
    chk("pri_req", mem_req, 1);
    chk("pri_we", mem_we, 1);
    chk("pri_addr", mem_addr, 15'h03B5);
    chk("pri_wdata", mem_wdata, 8'hC3);
    bus_iow_l = 1'b1;
    mon(3);
    bus_iow_l = 1'b0;
    mon(4);
    mem_ack = 1'b1;
    mon(1);
    mem_ack = 1'b0;
    chk("pri_req_drop", mem_req, 0);
    chk("memw_out_kept", bus_out, 8'hFF);
    mon(3);
    bus_iow_l  = 1'b1;
    bus_memw_l = 1'b1;
    mon(4);
    chk("pri_iowr", n_iowr, 0);

    // strobe released while waiting for ack
    bus_a = 20'hB0200;
    bus_memr_l = 1'b0;
    cyc(4);
    chk("rel_req", mem_req, 1);
    bus_memr_l = 1'b1;
    cyc(5);
    chk("rel_req_kept", mem_req, 1);
    mem_rdata = 8'h3C;
    mem_ack   = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    chk("rel_data", bus_out, 8'h3C);
    chk("rel_rdy", bus_rdy, 1);
    bus_a   = 20'h003B5;
    bus_din = 8'h21;
    clr();
    bus_iow_l = 1'b0;
    mon(5);
    chk("rel_next_iowr", n_iowr, 1);
    chk("rel_next_data", cap_wdata, 8'h21);
    bus_iow_l = 1'b1;
    cyc(4);

    // reset in the middle of a memory request
    bus_a = 20'hB0010;
    bus_memr_l = 1'b0;
    cyc(5);
    chk("rstm_req_pre", mem_req, 1);
    busreset = 1'b1;
    #1;
    chk("rstm_req", mem_req, 0);
    chk("rstm_rdy", bus_rdy, 1);
    chk("rstm_dir", bus_dir, 0);
    cyc(2);
    busreset = 1'b0;
    clr();
    mon(10);
    chk("rstm_held_req", seen_req, 0);
    chk("rstm_held_dir", seen_dir, 0);
    bus_memr_l = 1'b1;
    cyc(4);
    bus_memr_l = 1'b0;
    wait_req();
    chk("rstm_fresh_req", mem_req, 1);
    mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    bus_memr_l = 1'b1;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
